// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared constants, state encoding and funct3 decode helpers for the load/store unit.
package lsu_mem_ctrl_pkg;

    localparam int unsigned PORT_ADDR  = 32;
    localparam int unsigned PORT_DATA  = 32;
    localparam int unsigned LSU_WORD_W = PORT_DATA;

    localparam logic [LSU_WORD_W-1:0] LSU_ZERO_WORD = '0;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWrite  = 2'd2,
        StDone   = 2'd3
    } lsu_state_e;

    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            LSU_F3_B, LSU_F3_H, LSU_F3_W: ok = 1'b1;
            LSU_F3_BU, LSU_F3_HU:         ok = !we;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            LSU_F3_H, LSU_F3_HU: mis = off[0];
            LSU_F3_W:            mis = (off != 2'b00);
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Offset with the bits a halfword/word access may not use cleared.
    function automatic logic [1:0] lsu_align_down(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] res;
        res = off;
        case (f3)
            LSU_F3_H, LSU_F3_HU: res = {off[1], 1'b0};
            LSU_F3_W:            res = 2'b00;
            default:             res = off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract with sign/zero extension and store merge into a read word.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_offset,
    input  logic [LSU_WORD_W-1:0] i_rd_word,
    input  logic [LSU_WORD_W-1:0] i_wdata,
    output logic [LSU_WORD_W-1:0] o_load_data,
    output logic [LSU_WORD_W-1:0] o_merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rd_word[{i_offset, 3'b000} +: 8];
        w_half = i_rd_word[{i_offset[1], 4'b0000} +: 16];

        o_load_data = LSU_ZERO_WORD;
        case (i_funct3)
            LSU_F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            LSU_F3_BU: o_load_data = {24'h0, w_byte};
            LSU_F3_H:  o_load_data = {{16{w_half[15]}}, w_half};
            LSU_F3_HU: o_load_data = {16'h0, w_half};
            LSU_F3_W:  o_load_data = i_rd_word;
            default:   o_load_data = LSU_ZERO_WORD;
        endcase

        o_merge_word = i_rd_word;
        case (i_funct3)
            LSU_F3_B: o_merge_word[{i_offset, 3'b000} +: 8]      = i_wdata[7:0];
            LSU_F3_H: o_merge_word[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            LSU_F3_W: o_merge_word = i_wdata;
            default:  o_merge_word = i_rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-wide RAM without byte enables (SB/SH by read-modify-write).
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning down.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = PORT_ADDR,
    parameter int unsigned DATA_W = PORT_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rd_data
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_d;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [DATA_W-1:0] r_merge;
    logic [DATA_W-1:0] r_rdata;

    logic              w_req_err;
    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W-1:0] w_word_addr;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merge_word;

    assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign resp_rdata  = r_rdata;

    lsu_lane_align u_lane_align (
        .i_funct3     (r_funct3),
        .i_offset     (r_addr[1:0]),
        .i_rd_word    (mem_rd_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    always_comb begin
        w_req_err = !lsu_f3_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        w_req_err  = w_req_err | lsu_misaligned(req_funct3, req_addr[1:0]);
        w_req_addr = req_addr;
`else
        w_req_addr = {req_addr[ADDR_W-1:2], lsu_align_down(req_funct3, req_addr[1:0])};
`endif
    end

    always_comb begin
        w_state_d   = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;

        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_d = w_req_err ? StDone : StAccess;
                end
            end
            StAccess: begin
                mem_addr = w_word_addr;
                if (r_we && (r_funct3 == LSU_F3_W)) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = r_wdata;
                end
                w_state_d = (r_we && (r_funct3 != LSU_F3_W)) ? StWrite : StDone;
            end
            StWrite: begin
                mem_addr    = w_word_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = r_merge;
                w_state_d   = StDone;
            end
            StDone: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                w_state_d  = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        // Reset suppresses everything visible, so an abandoned RMW never writes.
        if (rst) begin
            req_ready   = 1'b0;
            resp_valid  = 1'b0;
            resp_err    = 1'b0;
            mem_wr_en   = 1'b0;
            mem_addr    = '0;
            mem_wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_merge  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == StIdle) && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= w_req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
                if (w_req_err) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == StAccess) begin
                if (!r_we) begin
                    r_rdata <= w_load_data;
                end else if (r_funct3 == LSU_F3_W) begin
                    r_rdata <= '0;
                end else begin
                    r_merge <= w_merge_word;
                end
            end
            if (r_state == StWrite) begin
                r_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed test-plan cases, then randomized traffic.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_data (mem_rd_data)
    );

    // RAM seen by the DUT (16 words, upper address bits alias) and the model's copy.
    logic [31:0] tb_mem  [16] = '{default: 32'h0};
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    assign mem_rd_data = tb_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_wr_en) tb_mem[mem_addr[5:2]] <= mem_wr_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   outstanding = 1'b0;
    int   wr_cnt = 0;
    int   wr_cyc = 0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    int   ready_viol = 0;
    int   hold_viol = 0;
    int   txn = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference: byte-level semantics of RV32I loads/stores on a word memory.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          off;
        int          size;
        int          idx;
        bit          legal;
        bit          mis;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] v;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.wr    = 0;
        e.wdata = 32'h0;
        e.waddr = {addr[31:2], 2'b00};
        e.name  = "";
        off  = int'(addr[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 < 3'd3) : (f3 != 3'd3 && f3 < 3'd6);
        mis   = (off % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) e.err = 1'b1;
`else
        if (mis) off = off - (off % size);
`endif
        if (!legal) e.err = 1'b1;
        if (e.err) begin
            e.lat = 1;
            return e;
        end
        idx  = int'(addr[5:2]);
        w    = ref_mem[idx];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        if (!we) begin
            v = (w >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
            e.rdata = v;
            e.lat   = 2;
        end else begin
            v = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            ref_mem[idx] = v;
            e.wr    = 1;
            e.wdata = v;
            e.lat   = (size == 4) ? 2 : 3;
        end
        return e;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        int   guard;
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        e = model(we, f3, a, wd);
        e.name = $sformatf("txn%0d", txn);
        txn++;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each response and tracks write/ready/hold behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (mem_wr_en) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_addr = mem_addr;
            wr_data = mem_wr_data;
        end
        if (rst) begin
            outstanding = 1'b0;
            last_rdata  = 32'h0;
        end else begin
            if (outstanding && req_ready) ready_viol++;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                    chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
                    chk({e.name, "_latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
                    chk({e.name, "_wr_count"}, 32'(wr_cnt), 32'(e.wr));
                    if (e.wr == 1 && wr_cnt == 1) begin
                        chk({e.name, "_wr_addr"}, wr_addr, e.waddr);
                        chk({e.name, "_wr_data"}, wr_data, e.wdata);
                        chk({e.name, "_wr_cycle"}, 32'(wr_cyc), 32'(cyc - 1));
                    end
                end
                last_rdata  = resp_rdata;
                outstanding = 1'b0;
                wr_cnt      = 0;
            end else if (resp_rdata !== last_rdata) begin
                hold_viol++;
            end
            if (req_valid && req_ready) begin
                outstanding = 1'b1;
                acc_cyc     = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          guard;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{LSU_F3_B, LSU_F3_H, LSU_F3_W, LSU_F3_BU, LSU_F3_HU};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'h1);
        chk("idle_mem_addr", mem_addr, 32'h0);

        // Sub-word loads.
        do_req(1'b1, LSU_F3_W,  32'h8000_1000, 32'h8123_45F6, 1'b0);
        do_req(1'b0, LSU_F3_B,  32'h8000_1000, 32'h0, 1'b0);
        do_req(1'b0, LSU_F3_BU, 32'h8000_1000, 32'h0, 1'b0);
        do_req(1'b0, LSU_F3_H,  32'h8000_1002, 32'h0, 1'b0);
        do_req(1'b0, LSU_F3_HU, 32'h8000_1002, 32'h0, 1'b0);
        // Read-modify-write.
        do_req(1'b1, LSU_F3_W, 32'h8000_1004, 32'h1122_3344, 1'b0);
        do_req(1'b1, LSU_F3_B, 32'h8000_1006, 32'h0000_00AB, 1'b0);
        do_req(1'b1, LSU_F3_H, 32'h8000_1004, 32'h0000_BEEF, 1'b0);
        do_req(1'b0, LSU_F3_W, 32'h8000_1004, 32'h0, 1'b0);
        // Word store and readback.
        do_req(1'b1, LSU_F3_W, 32'h8000_1008, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, LSU_F3_W, 32'h8000_1008, 32'h0, 1'b0);
        // Misaligned accesses.
        do_req(1'b0, LSU_F3_W, 32'h8000_100A, 32'h0, 1'b0);
        do_req(1'b1, LSU_F3_H, 32'h8000_1005, 32'h0000_1234, 1'b0);
        do_req(1'b0, LSU_F3_W, 32'h8000_1004, 32'h0, 1'b0);
        // Illegal funct3, back-to-back with req_valid held.
        do_req(1'b0, 3'b011, 32'h8000_1000, 32'h0, 1'b1);
        do_req(1'b1, 3'b100, 32'h8000_1000, 32'h0000_0077, 1'b1);
        do_req(1'b1, LSU_F3_B, 32'h8000_1001, 32'h0000_0042, 1'b1);
        do_req(1'b0, LSU_F3_W, 32'h8000_1000, 32'h0, 1'b0);

        // Reset during the WRITE cycle of an SB.
        do_req(1'b1, LSU_F3_W, 32'h8000_100C, 32'h5566_7788, 1'b0);
        while (!req_ready) begin
            @(posedge clk); #1;
        end
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = LSU_F3_B;
        req_addr   = 32'h8000_100D;
        req_wdata  = 32'h0000_0099;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rmw_rst_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rmw_rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rmw_rst_ready_after", 32'(req_ready), 32'h1);
        chk("rmw_rst_word", tb_mem[3], 32'h5566_7788);
        chk("rmw_rst_wr_count", 32'(wr_cnt), 32'h0);
        chk("rmw_rst_rdata", resp_rdata, 32'h0);
        wr_cnt = 0;

        // Randomized traffic, mostly legal funct3, random gaps or held valid.
        for (int i = 0; i < 250; i++) begin
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : legal_f3[$urandom_range(0, 4)];
            a  = {$urandom_range(0, 255) == 0 ? 26'h3FF_FFFF : 26'($urandom), 6'($urandom)};
            do_req(1'($urandom), f3, a, $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("pending_responses", 32'(exp_q.size()), 32'h0);
        chk("ready_low_while_busy", 32'(ready_viol), 32'h0);
        chk("rdata_hold", 32'(hold_viol), 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mem_word%0d", i), tb_mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
